prog_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 20 ++
 rtl/prog_loader_if.sv | 22 ++
 rtl/loader_word_asm.sv | 58 +++++
 rtl/prog_loader.sv | 146 ++++++++++++++
 tb/tb_prog_loader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot loader: FSM states and the RAM
// write-size encoding (matches the RAM's dw_size field).
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and RAM write port of the boot loader, bundled together.
// The loader is the slave of the byte stream and drives the write port.
interface prog_loader_if #(
    parameter int ADDR_W = 14
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [1:0]        wr_size;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_addr, wr_data, wr_size
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_addr, wr_data, wr_size
    );
endinterface

// File: rtl/loader_word_asm.sv
// Assembles little-endian 32-bit words from payload bytes and keeps the
// running modulo-256 checksum. word_out is valid while word_ready is high.
module loader_word_asm (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic        word_ready,
    output logic [31:0] word_out,
    output logic [7:0]  csum
);

    logic [1:0]  lane_q, lane_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  sum_q,  sum_d;

    // The fourth byte is merged combinationally so the word is available
    // in its acceptance cycle and can be registered onto the write port.
    assign word_ready = en && (lane_q == 2'd3);
    assign word_out   = {byte_in, word_q};
    assign csum       = sum_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        lane_d = lane_q;
        word_d = word_q;
        sum_d  = sum_q;
        if (clear) begin
            lane_d = 2'd0;
            word_d = '0;
            sum_d  = '0;
        end else if (en) begin
            lane_d = lane_q + 2'd1;
            sum_d  = sum_q + byte_in;
            case (lane_q)
                2'd0:    word_d[7:0]   = byte_in;
                2'd1:    word_d[15:8]  = byte_in;
                2'd2:    word_d[23:16] = byte_in;
                default: word_d        = '0;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments; the reset is synchronous, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lane_q <= 2'd0;
            word_q <= '0;
            sum_q  <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            sum_q  <= sum_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses MAGIC/LEN/payload/CSUM packets from a byte stream,
// writes the payload into RAM and releases the core once the image verifies.
module prog_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] MAGIC     = 8'hA5,
    parameter int         MAX_WORDS = 4096,
    parameter int         TIMEOUT   = 100000,
    parameter int         ADDR_W    = 14
) (
    input  logic         clk,
    input  logic         resetn,
    prog_loader_if.slave bus,
    output logic         core_hold,
    output logic         done,
    output logic         error
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [1:0]        wr_size_q, wr_size_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic        accept, is_magic, timed, timeout_hit, last_word;
    logic [15:0] len_w;
    logic        asm_clear, asm_en, word_ready;
    logic [31:0] asm_word;
    logic [7:0]  csum;

    assign accept      = bus.rx_valid && bus.rx_ready;
    assign is_magic    = (bus.rx_data == MAGIC);
    assign len_w       = {bus.rx_data, len_lo_q};
    assign last_word   = (16'(word_idx_q) + 16'd1 == len_q);
    assign timed       = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                         (state_q == DATA)   || (state_q == CSUM);
    assign timeout_hit = timed && !accept && (idle_cnt_q == CNT_W'(TIMEOUT - 1));

    loader_word_asm u_word_asm (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (asm_clear),
        .en         (asm_en),
        .byte_in    (bus.rx_data),
        .word_ready (word_ready),
        .word_out   (asm_word),
        .csum       (csum)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept && is_magic) state_d = LEN_LO;
            LEN_LO: if (accept) state_d = LEN_HI;
            LEN_HI: if (accept) begin
                        if (len_w > 16'(MAX_WORDS)) state_d = ERR;
                        else if (len_w == 16'd0)    state_d = CSUM;
                        else                        state_d = DATA;
                    end
            DATA:   if (word_ready && last_word) state_d = CSUM;
            CSUM:   if (accept) state_d = (bus.rx_data == csum) ? DONE : ERR;
            DONE:   state_d = DONE;
            ERR:    if (accept && is_magic) state_d = LEN_LO;
            default: state_d = IDLE;
        endcase
        if (timeout_hit) state_d = ERR;
    end

    always_comb begin
        bus.rx_ready = (state_q != DONE);
        done         = (state_q == DONE);
        core_hold    = (state_q != DONE);
        error        = (state_q == ERR);
    end

    // Datapath: length capture, word indexing, idle timer and the write pulse.
    always_comb begin
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        idle_cnt_d = (timed && !accept) ? idle_cnt_q + 1'b1 : '0;
        wr_size_d  = SZ_NONE;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        asm_clear  = 1'b0;
        asm_en     = 1'b0;
        if (accept) begin
            unique case (state_q)
                IDLE, ERR: if (is_magic) begin
                    asm_clear  = 1'b1;
                    word_idx_d = '0;
                    len_lo_d   = '0;
                    len_d      = '0;
                end
                LEN_LO: len_lo_d = bus.rx_data;
                LEN_HI: len_d    = len_w;
                DATA: begin
                    asm_en = 1'b1;
                    if (word_ready) begin
                        wr_size_d  = SZ_WORD;
                        wr_addr_d  = {word_idx_q, 2'b00};
                        wr_data_d  = asm_word;
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            idle_cnt_q <= '0;
            wr_size_q  <= SZ_NONE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            idle_cnt_q <= idle_cnt_d;
            wr_size_q  <= wr_size_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.wr_size = wr_size_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every write pulse the DUT emits.
module tb_prog_loader;
    import loader_pkg::*;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic core_hold, done, error;

    prog_loader_if #(.ADDR_W(14)) bus ();

    prog_loader #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.wr_size != SZ_NONE) begin
            if (bus.wr_size != SZ_WORD) begin
                check("wr_size_code", {30'd0, bus.wr_size}, {30'd0, SZ_WORD});
            end else if (exp_q.size() == 0) begin
                check("unexpected_write", {30'd0, bus.wr_size}, {30'd0, SZ_NONE});
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {18'd0, bus.wr_addr}, {18'd0, e.addr});
                check("wr_data", bus.wr_data, e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge right after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            for (int i = 0; i < g; i++) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (!bus.rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) begin
            check("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
            bus.rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] bs[$], input bit gaps);
        foreach (bs[i]) send_byte(bs[i], gaps);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},  {31'd0, bus.rx_ready}, 32'd1);
        check({tag, "_wr_size"},   {30'd0, bus.wr_size},  32'd0);
        check({tag, "_wr_addr"},   {18'd0, bus.wr_addr},  32'd0);
        check({tag, "_wr_data"},   bus.wr_data,           32'd0);
        check({tag, "_core_hold"}, {31'd0, core_hold},    32'd1);
        check({tag, "_done"},      {31'd0, done},         32'd0);
        check({tag, "_error"},     {31'd0, error},        32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_good_writes();
        exp_q.push_back('{14'h0000, 32'h0000_0013});
        exp_q.push_back('{14'h0004, 32'h0010_0093});
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},      {31'd0, done},         32'd1);
        check({tag, "_core_hold"}, {31'd0, core_hold},    32'd0);
        check({tag, "_rx_ready"},  {31'd0, bus.rx_ready}, 32'd0);
        check({tag, "_error"},     {31'd0, error},        32'd0);
        check({tag, "_pending"},   exp_q.size(),          32'd0);
    endtask

    initial begin
        logic [7:0] pkt[$];
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        resetn       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        resetn = 1'b1;
        @(negedge clk);

        // Two-word image, good checksum; also check the one-cycle write latency.
        push_good_writes();
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send_bytes(pkt, 1'b0);
        send_byte(8'h00, 1'b0);
        check("wr_pulse_latency", {30'd0, bus.wr_size}, {30'd0, SZ_WORD});
        pkt = '{8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_bytes(pkt, 1'b0);
        check_done("good");

        // Bad checksum, then recovery with a good packet from ERR.
        do_reset();
        push_good_writes();
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        send_bytes(pkt, 1'b0);
        check("badsum_error",     {31'd0, error},        32'd1);
        check("badsum_done",      {31'd0, done},         32'd0);
        check("badsum_core_hold", {31'd0, core_hold},    32'd1);
        check("badsum_rx_ready",  {31'd0, bus.rx_ready}, 32'd1);
        check("badsum_pending",   exp_q.size(),          32'd0);
        push_good_writes();
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_bytes(pkt, 1'b0);
        check_done("recover");

        // LEN = 4097 exceeds the RAM: error straight after LEN_HI, no writes.
        do_reset();
        pkt = '{8'hA5, 8'h01, 8'h10};
        send_bytes(pkt, 1'b0);
        check("toolong_error",     {31'd0, error},     32'd1);
        check("toolong_core_hold", {31'd0, core_hold}, 32'd1);
        repeat (4) @(negedge clk);
        check("toolong_pending",   exp_q.size(),       32'd0);

        // Empty image: LEN = 0 and CSUM = 0.
        do_reset();
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_bytes(pkt, 1'b0);
        check_done("empty");

        // Stall mid-word: timeout of 16 idle cycles forces ERR.
        do_reset();
        pkt = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_bytes(pkt, 1'b0);
        repeat (5) @(negedge clk);
        check("stall_early_error", {31'd0, error},     32'd0);
        repeat (20) @(negedge clk);
        check("timeout_error",     {31'd0, error},     32'd1);
        check("timeout_core_hold", {31'd0, core_hold}, 32'd1);
        check("timeout_pending",   exp_q.size(),       32'd0);

        // Garbage before MAGIC, irregular rx_valid during the packet.
        do_reset();
        pkt = '{8'h00, 8'hFF, 8'h5A};
        send_bytes(pkt, 1'b1);
        check("garbage_error",    {31'd0, error},        32'd0);
        check("garbage_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        push_good_writes();
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        send_bytes(pkt, 1'b1);
        check_done("gappy");

        // Reset in the middle of a word: reset values, no write emitted.
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
        do_reset();
        send_bytes(pkt, 1'b1);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("midrst");
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_pending", exp_q.size(),    32'd0);
        check("midrst_wr_size", {30'd0, bus.wr_size}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
